fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage sequencer that owns the architectural fetch PC, drives the single-outstanding instruction-bus request, and delivers one fetched instruction at a time to decode. It arbitrates two redirect sources, writeback (trap/CSR) over execute (branch/jump), and resolves redirects that arrive while a bus transaction is in flight. It sits between the next-PC selection logic and the decode pipeline register.

## Interface

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- redir_w_valid  in  1  writeback-stage redirect request (highest priority).
- redir_w_pc  in  64  writeback redirect target.
- redir_e_valid  in  1  execute-stage redirect request.
- redir_e_pc  in  64  execute redirect target.
- stall  in  1  decode cannot accept; hold the delivered instruction.
- ireq_valid  out  1  instruction-bus request.
- ireq_addr  out  64  request address; stable while ireq_valid=1 until iresp_ok.
- iresp_ok  in  1  single-cycle response strobe for the outstanding request.
- iresp_data  in  32  instruction word, valid with iresp_ok.
- out_valid  out  1  instruction available to decode.
- out_pc  out  64  PC of the delivered instruction.
- out_instr  out  32  delivered instruction word.

## Operation

- Redirect pick: redir = redir_w_valid | redir_e_valid; tgt = redir_w_valid ? redir_w_pc : redir_e_pc. Targets are used unmodified, with no alignment masking.
- States: IDLE, REQ, DISCARD, VALID.
- IDLE: all outputs idle; always go to REQ next cycle. If redir is asserted, pc takes tgt first.
- REQ: ireq_valid=1, ireq_addr=pc.
  - iresp_ok & !redir: capture out_pc=pc and out_instr=iresp_data, go to VALID.
  - iresp_ok & redir: drop the data, pc=tgt, stay in REQ (new request next cycle).
  - !iresp_ok & redir: pending=tgt, go to DISCARD.
- DISCARD: ireq_valid=1 with the old address held, because the address must not change mid-transaction.
  - A further redir overwrites pending; the latest request wins.
  - On iresp_ok: drop the data, pc = redir ? tgt : pending, go to REQ.
- VALID: out_valid=1.
  - redir: drop the instruction, pc=tgt, go to REQ. Redirect beats stall.
  - !stall: pc=pc+4, go to REQ.
  - stall: hold out_pc and out_instr unchanged.
- pc+4 is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- out_valid is 0 in every state except VALID. ireq_valid is 1 only in REQ and DISCARD.
- At most one bus transaction is outstanding. The bus must never see ireq_addr change while ireq_valid=1 and no iresp_ok has arrived.

## Timing

- Reset (synchronous): state=IDLE, pc=RESET_PC, pending=0, ireq_valid=0, ireq_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0. First request is in the second cycle after reset deasserts.
- Reset mid-transaction abandons the request. The instruction bus shares this reset.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Latency: request cycle with iresp_ok → out_valid in the next cycle. For a bus with iresp_ok in the first request cycle and stall=0, steady throughput is one instruction per 2 cycles.
- A redirect seen in VALID or REQ+iresp_ok gives a request to tgt in the next cycle. A redirect seen in DISCARD takes effect in the cycle after iresp_ok.

## Structure

- fetch_state_t (IDLE, REQ, DISCARD, VALID) goes in the pipes package. u64/u32 come from common.
- Sub-module fetch_redirect_mux: combinational W/E priority pick producing redir and tgt. It is reused by later interrupt sources.
- Top-level fetch_ctrl holds the FSM and the pc, pending and out registers.

## Test plan

- Reset release, bus answers iresp_ok on first request cycle with 32'h0000_0013, stall=0 → requests at 8000_0000, 8000_0004, 8000_0008. out_valid pulses every 2nd cycle with matching out_pc.
- stall=1 for 3 cycles in VALID → out_pc and out_instr held, ireq_valid=0 throughout. Release → request at pc+4.
- redir_e to 8000_0100 while REQ pending (iresp_ok delayed 4 cycles) → ireq_addr stays unchanged, response dropped (no out_valid), next request at 8000_0100.
- Same cycle redir_w=8000_0200 and redir_e=8000_0300 in VALID → instruction dropped, next request at 8000_0200.
- In DISCARD, redir_e to 8000_0400 then redir_e to 8000_0500 before iresp_ok → next request at 8000_0500.
- reset asserted mid-REQ → next cycle all outputs at reset values. Restart fetches RESET_PC. Redirect to FFFF_FFFF_FFFF_FFFC, then deliver → next request at 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch stage: bus word types and the fetch FSM encoding.
package fetch_ctrl_pkg;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2,
    VALID   = 2'd3
  } fetch_state_t;

  localparam u64 PC_STEP = 64'd4;

  // Sequential next PC; wraps modulo 2^64 by plain truncation.
  function automatic u64 next_seq_pc(input u64 pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/fetch_redirect_mux.sv
// Redirect source arbiter: writeback beats execute. Purely combinational so
// further sources can be chained in front of it later.
module fetch_redirect_mux
  import fetch_ctrl_pkg::*;
(
  input  logic w_valid,
  input  u64   w_pc,
  input  logic e_valid,
  input  u64   e_pc,
  output logic redir,
  output u64   tgt
);
  // Priority pick; targets pass through untouched (no alignment masking).
  always_comb begin
    redir = w_valid | e_valid;
    tgt   = w_valid ? w_pc : e_pc;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one bus request at a time and
// hands one instruction at a time to decode. Redirects arriving while a bus
// transaction is in flight are parked in 'pending' until the response lands,
// so the bus never sees the address move mid-transaction.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redir_w_valid,
  input  logic [63:0] redir_w_pc,
  input  logic        redir_e_valid,
  input  logic [63:0] redir_e_pc,
  input  logic        stall,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);
  fetch_state_t state, state_nxt;
  u64   pc, pc_nxt;
  u64   pending, pending_nxt;
  logic capture;
  logic redir;
  u64   tgt;

  fetch_redirect_mux u_redir (
    .w_valid (redir_w_valid),
    .w_pc    (redir_w_pc),
    .e_valid (redir_e_valid),
    .e_pc    (redir_e_pc),
    .redir   (redir),
    .tgt     (tgt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, next PC / pending target, and instruction capture strobe.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pending_nxt = pending;
    capture     = 1'b0;
    unique case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redir) pc_nxt = tgt;
      end
      REQ: begin
        if (iresp_ok && !redir) begin
          capture   = 1'b1;
          state_nxt = VALID;
        end else if (iresp_ok) begin
          pc_nxt = tgt;  // response dropped, reissue to target next cycle
        end else if (redir) begin
          pending_nxt = tgt;
          state_nxt   = DISCARD;
        end
      end
      DISCARD: begin
        if (iresp_ok) begin
          pc_nxt    = redir ? tgt : pending;
          state_nxt = REQ;
        end else if (redir) begin
          pending_nxt = tgt;  // latest redirect wins
        end
      end
      VALID: begin
        if (redir) begin
          pc_nxt    = tgt;
          state_nxt = REQ;
        end else if (!stall) begin
          pc_nxt    = next_seq_pc(pc);
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: PC, parked redirect target, delivered instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      pending   <= '0;
      out_pc    <= '0;
      out_instr <= '0;
    end else begin
      pc      <= pc_nxt;
      pending <= pending_nxt;
      if (capture) begin
        out_pc    <= pc;
        out_instr <= iresp_data;
      end
    end
  end

  // Outputs decode from registered state only; address is the held PC.
  assign ireq_valid = (state == REQ) || (state == DISCARD);
  assign ireq_addr  = pc;
  assign out_valid  = (state == VALID);
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random traffic, all
// checked cycle by cycle against a flag-based behavioural model.
module tb_fetch_ctrl;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redir_w_valid, redir_e_valid, stall, iresp_ok;
  logic [63:0] redir_w_pc, redir_e_pc;
  logic [31:0] iresp_data;
  logic        ireq_valid, out_valid;
  logic [63:0] ireq_addr, out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int failures = 0;

  fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .redir_w_valid(redir_w_valid), .redir_w_pc(redir_w_pc),
    .redir_e_valid(redir_e_valid), .redir_e_pc(redir_e_pc),
    .stall(stall),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  // Reference model, tracked as "what is fetch doing right now":
  // m_gap  - the single quiet cycle after reset
  // m_have - an instruction is being offered to decode
  // m_dead - a bus transaction is in flight whose data will be thrown away
  // otherwise a live request for m_pc is on the bus.
  logic        m_gap, m_have, m_dead;
  logic [63:0] m_pc, m_pend, m_opc;
  logic [31:0] m_oin;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: compare DUT against model, drive inputs, advance model.
  task automatic step(input logic rs, input logic w, input logic [63:0] wp,
                      input logic e, input logic [63:0] ep,
                      input logic st, input logic ok);
    logic        busy, okk, rd;
    logic [63:0] t;
    logic [31:0] d;
    busy = !m_gap && !m_have;
    chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, busy});
    chk("ireq_addr", ireq_addr, m_pc);
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_have});
    chk("out_pc", out_pc, m_opc);
    chk("out_instr", {32'd0, out_instr}, {32'd0, m_oin});
    okk = ok && busy && !rs;
    d   = $urandom;
    reset = rs; redir_w_valid = w; redir_w_pc = wp;
    redir_e_valid = e; redir_e_pc = ep; stall = st;
    iresp_ok = okk; iresp_data = d;
    rd = w | e;
    t  = w ? wp : ep;
    if (rs) begin
      m_gap = 1; m_have = 0; m_dead = 0; m_pc = RPC; m_pend = 0; m_opc = 0; m_oin = 0;
    end else if (m_gap) begin
      m_gap = 0;
      if (rd) m_pc = t;
    end else if (m_have) begin
      if (rd) begin m_have = 0; m_pc = t; end
      else if (!st) begin m_have = 0; m_pc = m_pc + 64'd4; end
    end else if (m_dead) begin
      if (okk) begin m_dead = 0; m_pc = rd ? t : m_pend; end
      else if (rd) m_pend = t;
    end else begin
      if (okk && !rd) begin m_have = 1; m_opc = m_pc; m_oin = d; end
      else if (okk) m_pc = t;
      else if (rd) begin m_dead = 1; m_pend = t; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic st, input logic ok);
    step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, st, ok);
  endtask

  // Run with an always-answering bus until an instruction is on offer.
  task automatic go_valid();
    int n = 0;
    while (!m_have && n < 20) begin idle(1'b0, 1'b1); n++; end
    chk("reach_valid", {63'd0, m_have}, 64'd1);
  endtask

  initial begin
    reset = 1; redir_w_valid = 0; redir_e_valid = 0; redir_w_pc = 0; redir_e_pc = 0;
    stall = 0; iresp_ok = 0; iresp_data = 0;
    m_gap = 1; m_have = 0; m_dead = 0; m_pc = RPC; m_pend = 0; m_opc = 0; m_oin = 0;
    @(negedge clk);
    step(1'b1, 0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0, 0);
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);

    // Back-to-back fetch with an instant bus.
    idle(0, 1);
    chk("first_req", ireq_addr, 64'h8000_0000);
    idle(0, 1);
    chk("first_out", out_pc, 64'h8000_0000);
    idle(0, 1);
    chk("second_req", ireq_addr, 64'h8000_0004);
    idle(0, 1); idle(0, 1);
    chk("third_req", ireq_addr, 64'h8000_0008);

    // Stall holds the delivered instruction.
    go_valid();
    idle(1, 0); idle(1, 0); idle(1, 0);
    chk("stall_hold", {63'd0, out_valid}, 64'd1);
    idle(0, 0);
    chk("after_stall", ireq_addr, m_opc + 64'd4);

    // Execute redirect during a slow response: address held, data dropped.
    step(0, 0, 0, 1, 64'h8000_0100, 0, 0);
    idle(0, 0); idle(0, 0); idle(0, 0);
    idle(0, 1);
    chk("redir_e_req", ireq_addr, 64'h8000_0100);
    chk("redir_e_drop", {63'd0, out_valid}, 64'd0);

    // Simultaneous redirects in VALID: writeback wins.
    go_valid();
    step(0, 1, 64'h8000_0200, 1, 64'h8000_0300, 0, 0);
    chk("w_beats_e", ireq_addr, 64'h8000_0200);

    // Two redirects while discarding: the later one wins.
    step(0, 0, 0, 1, 64'h8000_0400, 0, 0);
    step(0, 0, 0, 1, 64'h8000_0500, 0, 0);
    idle(0, 1);
    chk("latest_pending", ireq_addr, 64'h8000_0500);

    // Reset mid-request, then PC wrap.
    step(1, 0, 0, 0, 0, 0, 0);
    chk("midreq_rst", {63'd0, ireq_valid}, 64'd0);
    chk("midreq_rst_addr", ireq_addr, RPC);
    step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    chk("wrap_req", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    idle(0, 1);
    idle(0, 0);
    chk("wrap_zero", ireq_addr, 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] wp, ep;
      wp = ($urandom % 8 == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      ep = {32'd0, $urandom};
      step(($urandom % 200) == 0, ($urandom % 10) == 0, wp, ($urandom % 6) == 0, ep,
           ($urandom % 3) == 0, ($urandom % 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
